// File: rtl/md_pkg.sv
// Shared types and constants for the md_seq RV32M multiply/divide sequencer.
// Build option: SIGNED_DIV_EN enables signed DIV/REM (otherwise those ops are illegal).
package md_pkg;

    localparam int unsigned MD_DATA_WIDTH = 32;
    localparam int unsigned MD_CNT_W      = $clog2(MD_DATA_WIDTH);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } md_state_e;

    // Ops this build cannot execute; they complete early with resp_illegal.
    function automatic logic md_op_illegal(input md_op_e op);
        logic ill;
        case (op)
            OP_MULH, OP_MULHSU: ill = 1'b1;
`ifdef SIGNED_DIV_EN
            OP_DIV, OP_REM:     ill = 1'b0;
`else
            OP_DIV, OP_REM:     ill = 1'b1;
`endif
            default:            ill = 1'b0;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of shift-add multiply or restoring divide on the shared accumulator.
// Multiply acc = {carry, hi, lo(multiplier)}; divide acc = {rem[W:0], quotient/dividend}.
module md_step
    import md_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic [2*DATA_WIDTH:0]   acc_i,
    input  logic [DATA_WIDTH-1:0]   opnd_i,
    input  logic                    div_i,
    output logic [2*DATA_WIDTH:0]   acc_o
);
    localparam int unsigned W = DATA_WIDTH;

    logic [W-1:0] lo;
    logic [W:0]   mul_sum;
    logic [W:0]   div_shift;
    logic [W:0]   div_diff;

    always_comb begin
        lo        = acc_i[W-1:0];
        mul_sum   = acc_i[2*W:W] + (lo[0] ? {1'b0, opnd_i} : '0);
        div_shift = {acc_i[2*W-1:W], lo[W-1]};
        div_diff  = div_shift - {1'b0, opnd_i};
        if (div_i) begin
            // Restore (keep the shifted remainder) when the trial subtraction goes negative.
            if (!div_diff[W]) begin
                acc_o = {div_diff, lo[W-2:0], 1'b1};
            end else begin
                acc_o = {div_shift, lo[W-2:0], 1'b0};
            end
        end else begin
            acc_o = {1'b0, mul_sum, lo[W-1:1]};
        end
    end

endmodule

// File: rtl/md_seq.sv
// Multi-cycle RV32M multiply/divide sequencer running beside the execute-stage ALU.
// Build option: define SIGNED_DIV_EN to support signed DIV/REM with sign fix-up.
module md_seq
    import md_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_illegal
);
    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned AW    = 2 * DATA_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
`ifdef SIGNED_DIV_EN
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
`endif

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             div_q, div_d;
    logic             hi_q, hi_d;
    logic             illegal_q, illegal_d;
    logic             early_q, early_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [W-1:0]     result_q, result_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    acc_nxt;
`ifdef SIGNED_DIV_EN
    logic             neg_q, neg_d;
    logic             sgn_in;
`endif

    md_op_e       op_in;
    logic         accept;
    logic         is_div_in;
    logic         ill_in;
    logic         dz_in;
    logic         ovf_in;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic [W-1:0] early_res;
    logic [W-1:0] res_raw;
    logic [W-1:0] res_fix;

    assign req_ready    = (state_q == IDLE) && !flush;
    assign accept       = req_valid && req_ready;
    assign busy         = (state_q != IDLE);
    assign resp_valid   = (state_q == DONE) && !flush;
    assign resp_data    = resp_valid ? result_q : '0;
    assign resp_illegal = resp_valid && illegal_q;

    md_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .acc_o  (acc_nxt)
    );

    // Request decode: operand magnitudes and the result of any early-out case.
    always_comb begin
        op_in     = md_op_e'(req_op);
        is_div_in = req_op[2];
        ill_in    = md_op_illegal(op_in);
        dz_in     = is_div_in && (req_b == '0);
        ovf_in    = 1'b0;
        a_mag     = req_a;
        b_mag     = req_b;
        early_res = '0;
`ifdef SIGNED_DIV_EN
        sgn_in = (op_in == OP_DIV) || (op_in == OP_REM);
        neg_d  = neg_q;
        if (sgn_in) begin
            ovf_in = (req_a == MIN_NEG) && (&req_b);
            if (req_a[W-1]) a_mag = -req_a;
            if (req_b[W-1]) b_mag = -req_b;
        end
        if (accept) begin
            neg_d = sgn_in && (req_op[1] ? req_a[W-1] : (req_a[W-1] ^ req_b[W-1]));
        end
        if (!ill_in && ovf_in && !req_op[1]) early_res = MIN_NEG;
`endif
        // op bit 1 selects remainder over quotient for divide-by-zero.
        if (!ill_in && dz_in) early_res = req_op[1] ? req_a : '1;
    end

    // op bit 1 selects the high product half / remainder on the final iteration.
    always_comb begin
        res_raw = hi_q ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];
        res_fix = res_raw;
`ifdef SIGNED_DIV_EN
        if (neg_q) res_fix = -res_raw;
`endif
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        div_d     = div_q;
        hi_d      = hi_q;
        illegal_d = illegal_q;
        early_d   = early_q;
        opnd_d    = opnd_q;
        result_d  = result_q;
        acc_d     = acc_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    div_d     = is_div_in;
                    hi_d      = req_op[1];
                    illegal_d = ill_in;
                    early_d   = ill_in || dz_in || ovf_in;
                    result_d  = early_res;
                    opnd_d    = is_div_in ? b_mag : req_a;
                    acc_d     = {(W + 1)'(0), is_div_in ? a_mag : req_b};
                    count_d   = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (early_q) begin
                    // Early-out result was captured at accept; skip the iterations.
                    state_d = DONE;
                end else begin
                    acc_d   = acc_nxt;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        result_d = res_fix;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            div_q     <= 1'b0;
            hi_q      <= 1'b0;
            illegal_q <= 1'b0;
            early_q   <= 1'b0;
            opnd_q    <= '0;
            result_q  <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_q     <= div_d;
            hi_q      <= hi_d;
            illegal_q <= illegal_d;
            early_q   <= early_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            acc_q     <= acc_d;
        end
    end

`ifdef SIGNED_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`endif

endmodule

// File: tb/tb_md_seq.sv
// Scoreboard testbench for md_seq: directed RV32M cases plus random ops against a
// plain-arithmetic reference model; a negedge monitor pops and compares each response.
module tb_md_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_illegal;

    typedef struct {
        logic [31:0] data;
        logic        ill;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   c0;
    int   c1;

    md_seq #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .flush        (flush),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_illegal (resp_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural RV32M results, computed directly from the operand values.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic ill, output bit early);
        logic [63:0] p;
        int sa;
        int sbv;
        p     = 64'(a) * 64'(b);
        r     = '0;
        ill   = 1'b0;
        early = 1'b0;
        sa    = $signed(a);
        sbv   = $signed(b);
        case (op)
            3'b000: r = p[31:0];
            3'b011: r = p[63:32];
            3'b101: begin
                if (b == 0) begin early = 1'b1; r = 32'hFFFF_FFFF; end
                else r = a / b;
            end
            3'b111: begin
                if (b == 0) begin early = 1'b1; r = a; end
                else r = a % b;
            end
`ifdef SIGNED_DIV_EN
            3'b100, 3'b110: begin
                if (b == 0) begin
                    early = 1'b1;
                    r = (op == 3'b100) ? 32'hFFFF_FFFF : a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    early = 1'b1;
                    r = (op == 3'b100) ? 32'h8000_0000 : 32'h0;
                end else begin
                    r = (op == 3'b100) ? 32'(sa / sbv) : 32'(sa % sbv);
                end
            end
`endif
            default: begin
                ill   = 1'b1;
                early = 1'b1;
                r     = '0;
            end
        endcase
    endfunction

    // Call just after a rising edge; returns one cycle after acceptance, also post-edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int acc_cyc);
        logic [31:0] r;
        logic        ill;
        bit          early;
        bit          done;
        exp_t        e;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        done      = 1'b0;
        acc_cyc   = -1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: got no req_ready expected accept within 100 cycles (op %b)", op);
        end else if (push) begin
            ref_model(op, a, b, r, ill, early);
            e.data = r;
            e.ill  = ill;
            e.due  = acc_cyc + (early ? 2 : 33);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got data %h expected no response (cycle %0d)", resp_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_illegal", 32'(resp_illegal), 32'(e.ill));
                chk("resp_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_data", resp_data, 32'd0);
        chk("reset_resp_illegal", 32'(resp_illegal), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sync();

        // MUL 7 x 6: busy and req_ready profile across the whole operation.
        issue(3'b000, 32'd7, 32'd6, 1'b1, c0);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            chk("mul_busy_profile", 32'(busy), (k <= 33) ? 32'd1 : 32'd0);
            chk("mul_ready_profile", 32'(req_ready), (k <= 33) ? 32'd0 : 32'd1);
        end
        sync();

        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, c0);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, c0);
        issue(3'b101, 32'd100, 32'd7, 1'b1, c0);
        issue(3'b111, 32'd100, 32'd7, 1'b1, c0);
        issue(3'b101, 32'd5, 32'd0, 1'b1, c0);
        issue(3'b111, 32'd5, 32'd0, 1'b1, c0);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1, c0);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1, c0);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, c0);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, c0);
        issue(3'b100, 32'd9, 32'd0, 1'b1, c0);
        issue(3'b001, 32'd3, 32'd4, 1'b1, c0);
        issue(3'b010, 32'd3, 32'd4, 1'b1, c0);

        // Flush mid-divide, then a back-to-back MUL in the very next cycle.
        issue(3'b101, 32'd1000, 32'd3, 1'b0, c0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", 32'(req_ready), 32'd0);
        sync();
        flush = 1'b0;
        issue(3'b000, 32'd3, 32'd5, 1'b1, c1);
        chk("flush_reaccept_cycle", 32'(c1), 32'(c0 + 11));

        // Flush on the response cycle suppresses the strobe.
        issue(3'b000, 32'd9, 32'd9, 1'b0, c0);
        repeat (32) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_done_resp_valid", 32'(resp_valid), 32'd0);
        chk("flush_done_busy", 32'(busy), 32'd1);
        sync();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_done_idle", 32'(busy), 32'd0);
        sync();

        // Asynchronous reset mid-divide.
        issue(3'b101, 32'd1000, 32'd7, 1'b0, c0);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sync();
        issue(3'b101, 32'd9, 32'd3, 1'b1, c0);

        // Random operations with biased operands to hit the corner cases.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            issue(op, a, b, 1'b1, c0);
        end

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
